// File: rtl/rmw_sequencer.sv
// rmw_sequencer: drives the shared ALU for memory read-modify-write ops.
// Build option: define RMW_DUMMY_WRITE_EN for the 6502-style double write.
module rmw_sequencer #(
   parameter int         ADDR_W   = 16,
   parameter logic [2:0] ARG_SEL  = 3'b000,
   parameter int         WAIT_MAX = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        op_in,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic [3:0]        alu_op,
   output logic [2:0]        alu_arg_sel,
   output logic [7:0]        alu_arg,
   input  logic [7:0]        alu_result,
   input  logic [7:0]        alu_sr,
   output logic              sr_we,
   output logic [7:0]        sr_mask,
   output logic [7:0]        sr_out
);

   localparam logic [3:0] OP_ASL = 4'd5;
   localparam logic [3:0] OP_LSR = 4'd6;
   localparam logic [3:0] OP_ROL = 4'd7;
   localparam logic [3:0] OP_ROR = 4'd8;
   localparam logic [3:0] OP_INC = 4'd9;
   localparam logic [3:0] OP_DEC = 4'd10;
   localparam logic [3:0] OP_TST = 4'd11;

   localparam int CNT_W = (WAIT_MAX > 255) ? $clog2(WAIT_MAX + 1) : 8;
   localparam bit TO_EN = (WAIT_MAX > 0);
   localparam logic [CNT_W-1:0] WMAX_M1 = CNT_W'(WAIT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MOD,
`ifdef RMW_DUMMY_WRITE_EN
      S_DWR,
`endif
      S_WR,
      S_FIN
   } state_t;

   state_t           state, state_n;
   logic [3:0]       op_q;
   logic [7:0]       res;
   logic [2:0]       flg;
   logic [CNT_W-1:0] cnt;
   logic             err_n;
   logic             op_ok;
   logic             strobe;
   logic             tmo;
   logic             wr_n;
   logic [7:0]       wdata_n;
   logic             unused_sr;

   assign unused_sr = ^alu_sr[6:2];
   assign op_ok = op_in inside {OP_ASL, OP_LSR, OP_ROL,
                                OP_ROR, OP_INC, OP_DEC};
   assign strobe = mem_rd | mem_wr;
   assign tmo = TO_EN && strobe && !mem_ready && (cnt == WMAX_M1);

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (op_ok) state_n = S_RD;
               else       err_n   = 1'b1;
            end
         end
         S_RD: begin
            if (mem_ready) begin
               state_n = S_MOD;
            end else if (tmo) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end
         end
`ifdef RMW_DUMMY_WRITE_EN
         S_MOD: state_n = S_DWR;
         S_DWR: begin
            if (mem_ready) begin
               state_n = S_WR;
            end else if (tmo) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end
         end
`else
         S_MOD: state_n = S_WR;
`endif
         S_WR: begin
            if (mem_ready) begin
               state_n = S_FIN;
            end else if (tmo) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // alu_arg doubles as the latch for the original byte
   always_comb begin
      wr_n    = 1'b0;
      wdata_n = 8'h00;
      if (state_n == S_WR) begin
         wr_n    = 1'b1;
         wdata_n = (state == S_MOD) ? alu_result : res;
      end
`ifdef RMW_DUMMY_WRITE_EN
      if (state_n == S_DWR) begin
         wr_n    = 1'b1;
         wdata_n = alu_arg;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         op_q        <= 4'h0;
         res         <= 8'h00;
         flg         <= 3'b000;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_wdata   <= 8'h00;
         alu_op      <= OP_TST;
         alu_arg_sel <= ARG_SEL;
         alu_arg     <= 8'h00;
         sr_we       <= 1'b0;
         sr_mask     <= 8'h00;
         sr_out      <= 8'h00;
      end else begin
         state       <= state_n;
         busy        <= (state_n != S_IDLE);
         done        <= (state_n == S_FIN);
         sr_we       <= (state_n == S_FIN);
         sr_mask     <= (state_n == S_FIN) ? 8'h83 : 8'h00;
         sr_out      <= (state_n == S_FIN) ?
                        {flg[2], 5'b0, flg[1], flg[0]} : 8'h00;
         error       <= err_n;
         mem_rd      <= (state_n == S_RD);
         mem_wr      <= wr_n;
         mem_wdata   <= wdata_n;
         alu_op      <= (state_n == S_MOD) ? op_q : OP_TST;
         alu_arg_sel <= ARG_SEL;
         cnt         <= (strobe && !mem_ready) ?
                        cnt + CNT_W'(1) : '0;
         if (state == S_IDLE && state_n == S_RD) begin
            op_q     <= op_in;
            mem_addr <= addr_in;
         end
         if (state == S_RD && mem_ready)
            alu_arg <= mem_rdata;
         if (state == S_MOD) begin
            res <= alu_result;
            flg <= {alu_sr[7], alu_sr[1], alu_sr[0]};
         end
      end
   end

endmodule

// File: tb/tb_rmw_sequencer.sv
// tb_rmw_sequencer: directed bench with a simple bus responder and ALU stub.
// Expectations follow RMW_DUMMY_WRITE_EN when it is defined.
`timescale 1ns/1ps
module tb_rmw_sequencer;

   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_ASL = 4'd5;
   localparam logic [3:0] OP_LSR = 4'd6;
   localparam logic [3:0] OP_ROL = 4'd7;
   localparam logic [3:0] OP_ROR = 4'd8;
   localparam logic [3:0] OP_INC = 4'd9;
   localparam logic [3:0] OP_DEC = 4'd10;
   localparam logic [3:0] OP_TST = 4'd11;
`ifdef RMW_DUMMY_WRITE_EN
   localparam int DW = 1;
`else
   localparam int DW = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op_in = 4'h0;
   logic [15:0] addr_in = 16'h0;
   logic        busy, done, error, mem_rd, mem_wr, sr_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, sr_mask, sr_out;
   logic        mem_ready = 1'b0;
   logic [3:0]  alu_op;
   logic [2:0]  alu_arg_sel;
   logic [7:0]  alu_arg, alu_result, alu_sr;

   logic [7:0]  mem [0:65535];
   int vec = 0;
   int miss = 0;

   always #5 clk = ~clk;

   rmw_sequencer #(.ADDR_W(16), .ARG_SEL(3'b000), .WAIT_MAX(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op_in(op_in),
      .addr_in(addr_in), .busy(busy), .done(done), .error(error),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .alu_op(alu_op),
      .alu_arg_sel(alu_arg_sel), .alu_arg(alu_arg),
      .alu_result(alu_result), .alu_sr(alu_sr), .sr_we(sr_we),
      .sr_mask(sr_mask), .sr_out(sr_out)
   );

   assign mem_rdata = mem[mem_addr];

   // ALU stub: latches op/arg on negedge; sr bits 6..2 forced high
   logic [3:0] a_op = 4'h0;
   logic [7:0] a_arg = 8'h0;
   logic       alu_c = 1'b0;
   always @(negedge clk) begin
      a_op  = alu_op;
      a_arg = alu_arg;
   end
   always_comb begin
      logic [7:0] r;
      logic       c;
      r = a_arg;
      c = alu_c;
      case (a_op)
         OP_ASL: begin r = {a_arg[6:0], 1'b0};  c = a_arg[7]; end
         OP_LSR: begin r = {1'b0, a_arg[7:1]};  c = a_arg[0]; end
         OP_ROL: begin r = {a_arg[6:0], alu_c}; c = a_arg[7]; end
         OP_ROR: begin r = {alu_c, a_arg[7:1]}; c = a_arg[0]; end
         OP_INC: r = a_arg + 8'd1;
         OP_DEC: r = a_arg - 8'd1;
         default: r = a_arg;
      endcase
      alu_result = r;
      alu_sr = {r[7], 5'b11111, (r == 8'h00), c};
   end

   // bus responder: ready after lat wait cycles, never if hold_low
   int   lat = 0;
   int   wcnt = 0;
   logic hold_low = 1'b0;
   always @(negedge clk) begin
      if (mem_ready || !(mem_rd || mem_wr)) wcnt = 0;
      mem_ready = (mem_rd || mem_wr) && !hold_low && (wcnt >= lat);
      if (mem_rd || mem_wr) wcnt++;
   end

   int rd_cyc, wr_cyc, both, busy_cyc, done_cnt, err_cnt, we_cnt, nwr;
   logic [7:0] first_wd;
   always @(posedge clk) begin
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if (mem_rd && mem_wr) both++;
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (sr_we) we_cnt++;
      if (mem_wr && mem_ready) begin
         if (nwr == 0) first_wd = mem_wdata;
         mem[mem_addr] = mem_wdata;
         nwr++;
      end
   end

   task automatic clr();
      rd_cyc = 0; wr_cyc = 0; both = 0; busy_cyc = 0;
      done_cnt = 0; err_cnt = 0; we_cnt = 0; nwr = 0;
      first_wd = 8'h00;
   endtask

   task automatic pulse(input logic [3:0] op, input logic [15:0] a);
      @(negedge clk);
      start = 1'b1; op_in = op; addr_in = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   // cycle index (start cycle = 1) at which done or error is seen
   task automatic wait_end(output int n);
      n = 2;
      while (!done && !error && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vec++; if (busy !== 1'b0) begin miss++;
         $display("FAIL rst_busy: got %b exp 0", busy); end
      vec++; if ({done, error, sr_we} !== 3'b000) begin miss++;
         $display("FAIL rst_pulses: got %b exp 000", {done, error, sr_we}); end
      vec++; if ({mem_rd, mem_wr} !== 2'b00) begin miss++;
         $display("FAIL rst_strobes: got %b exp 00", {mem_rd, mem_wr}); end
      vec++; if (alu_op !== OP_TST) begin miss++;
         $display("FAIL rst_alu_op: got %h exp %h", alu_op, OP_TST); end
      vec++; if (alu_arg_sel !== 3'b000) begin miss++;
         $display("FAIL rst_arg_sel: got %b exp 000", alu_arg_sel); end
      vec++; if ({mem_addr, mem_wdata, sr_mask, sr_out, alu_arg} !== 48'h0) begin
         miss++;
         $display("FAIL rst_data: got %h exp 0",
                  {mem_addr, mem_wdata, sr_mask, sr_out, alu_arg}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_asl();
      int n;
      clr(); lat = 0; alu_c = 1'b0;
      mem[16'h0200] = 8'h81;
      pulse(OP_ASL, 16'h0200);
      wait_end(n);
      vec++; if (n !== 5 + DW) begin miss++;
         $display("FAIL asl_latency: got %0d exp %0d", n, 5 + DW); end
      vec++; if ({sr_we, sr_mask} !== 9'h183) begin miss++;
         $display("FAIL asl_sr_mask: got %b/%h exp 1/83", sr_we, sr_mask); end
      vec++; if (sr_out !== 8'h01) begin miss++;
         $display("FAIL asl_sr_out: got %h exp 01", sr_out); end
      repeat (2) @(negedge clk);
      vec++; if (mem[16'h0200] !== 8'h02) begin miss++;
         $display("FAIL asl_mem: got %h exp 02", mem[16'h0200]); end
      vec++; if (nwr !== 1 + DW) begin miss++;
         $display("FAIL asl_nwr: got %0d exp %0d", nwr, 1 + DW); end
      vec++; if (first_wd !== (DW ? 8'h81 : 8'h02)) begin miss++;
         $display("FAIL asl_first_wd: got %h", first_wd); end
      vec++; if (busy_cyc !== 4 + DW || busy !== 1'b0) begin miss++;
         $display("FAIL asl_busy: got %0d/%b exp %0d/0",
                  busy_cyc, busy, 4 + DW); end
      vec++; if (done_cnt !== 1 || we_cnt !== 1) begin miss++;
         $display("FAIL asl_pulses: got %0d/%0d exp 1/1", done_cnt, we_cnt); end
   endtask

   task automatic test_inc_wait();
      int n;
      clr(); lat = 3; alu_c = 1'b0;
      mem[16'h1234] = 8'hFF;
      pulse(OP_INC, 16'h1234);
      wait_end(n);
      vec++; if (n !== 11 + 4 * DW) begin miss++;
         $display("FAIL inc_latency: got %0d exp %0d", n, 11 + 4 * DW); end
      vec++; if (sr_out !== 8'h02) begin miss++;
         $display("FAIL inc_sr_out: got %h exp 02", sr_out); end
      repeat (2) @(negedge clk);
      vec++; if (mem[16'h1234] !== 8'h00) begin miss++;
         $display("FAIL inc_mem: got %h exp 00", mem[16'h1234]); end
      vec++; if (rd_cyc !== 4 || wr_cyc !== 4 * (1 + DW)) begin miss++;
         $display("FAIL inc_strobe_hold: got rd %0d wr %0d exp 4 %0d",
                  rd_cyc, wr_cyc, 4 * (1 + DW)); end
      vec++; if (err_cnt !== 0) begin miss++;
         $display("FAIL inc_err: got %0d exp 0", err_cnt); end
      lat = 0;
   endtask

   logic [3:0] t_op [5] = '{OP_LSR, OP_ROL, OP_ROR, OP_DEC, OP_INC};
   logic [7:0] t_in [5] = '{8'h01, 8'h80, 8'h02, 8'h00, 8'h7F};
   logic       t_c  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [7:0] t_res[5] = '{8'h00, 8'h01, 8'h81, 8'hFF, 8'h80};
   logic [7:0] t_sr [5] = '{8'h03, 8'h01, 8'h80, 8'h80, 8'h81};

   task automatic test_ops();
      int n;
      for (int i = 0; i < 5; i++) begin
         logic [15:0] a;
         a = 16'h0300 + 16'(i);
         clr(); alu_c = t_c[i];
         mem[a] = t_in[i];
         pulse(t_op[i], a);
         wait_end(n);
         vec++; if (sr_out !== t_sr[i]) begin miss++;
            $display("FAIL op%0d_sr_out: got %h exp %h", i, sr_out, t_sr[i]); end
         repeat (2) @(negedge clk);
         vec++; if (mem[a] !== t_res[i]) begin miss++;
            $display("FAIL op%0d_mem: got %h exp %h", i, mem[a], t_res[i]); end
      end
      alu_c = 1'b0;
   endtask

   task automatic test_illegal();
      int n;
      clr();
      pulse(OP_AND, 16'h0700);
      wait_end(n);
      vec++; if (n !== 2 || error !== 1'b1) begin miss++;
         $display("FAIL ill_err_time: got %0d/%b exp 2/1", n, error); end
      repeat (4) @(negedge clk);
      vec++; if (err_cnt !== 1) begin miss++;
         $display("FAIL ill_err_cnt: got %0d exp 1", err_cnt); end
      vec++; if (rd_cyc + wr_cyc + busy_cyc !== 0) begin miss++;
         $display("FAIL ill_activity: got rd %0d wr %0d busy %0d exp 0",
                  rd_cyc, wr_cyc, busy_cyc); end
   endtask

   task automatic test_timeout();
      int n;
      clr(); hold_low = 1'b1;
      pulse(OP_ASL, 16'h0400);
      wait_end(n);
      vec++; if (n !== 6 || error !== 1'b1) begin miss++;
         $display("FAIL to_err_time: got %0d/%b exp 6/1", n, error); end
      vec++; if (mem_rd !== 1'b0) begin miss++;
         $display("FAIL to_rd_drop: got %b exp 0", mem_rd); end
      repeat (3) @(negedge clk);
      hold_low = 1'b0;
      vec++; if (rd_cyc !== 4) begin miss++;
         $display("FAIL to_rd_cycles: got %0d exp 4", rd_cyc); end
      vec++; if (err_cnt !== 1 || we_cnt !== 0 || done_cnt !== 0) begin
         miss++;
         $display("FAIL to_pulses: got err %0d we %0d done %0d exp 1 0 0",
                  err_cnt, we_cnt, done_cnt); end
      vec++; if (busy !== 1'b0 || wr_cyc !== 0) begin miss++;
         $display("FAIL to_idle: got busy %b wr %0d exp 0 0", busy, wr_cyc); end
   endtask

   task automatic test_reset_mid();
      int n;
      int k;
      clr(); lat = 3;
      mem[16'h0500] = 8'h01;
      pulse(OP_ASL, 16'h0500);
      k = 0;
      while (!(mem_wr && mem_wdata == 8'h02) && k < 40) begin
         @(negedge clk);
         k++;
      end
      vec++; if (k >= 40) begin miss++;
         $display("FAIL rm_reach_wr: got %0d cycles exp <40", k); end
      reset = 1'b1;
      @(negedge clk);
      vec++; if (mem_wr !== 1'b0 || busy !== 1'b0) begin miss++;
         $display("FAIL rm_drop: got wr %b busy %b exp 0 0", mem_wr, busy); end
      reset = 1'b0;
      lat = 0;
      pulse(OP_ASL, 16'h0500);
      wait_end(n);
      vec++; if (n !== 5 + DW) begin miss++;
         $display("FAIL rm_restart: got %0d exp %0d", n, 5 + DW); end
      repeat (2) @(negedge clk);
      vec++; if (done_cnt !== 1 || we_cnt !== 1 || err_cnt !== 0) begin
         miss++;
         $display("FAIL rm_pulses: got done %0d we %0d err %0d exp 1 1 0",
                  done_cnt, we_cnt, err_cnt); end
      vec++; if (mem[16'h0500] !== 8'h02) begin miss++;
         $display("FAIL rm_mem: got %h exp 02", mem[16'h0500]); end
   endtask

   task automatic test_back_to_back();
      int n;
      clr(); lat = 0;
      mem[16'h0600] = 8'h10;
      mem[16'h0601] = 8'h20;
      pulse(OP_ASL, 16'h0600);
      @(negedge clk);
      start = 1'b1; op_in = OP_ASL; addr_in = 16'h0601;
      @(negedge clk);
      start = 1'b0;
      wait_end(n);
      vec++; if (sr_out !== 8'h00 || done !== 1'b1) begin miss++;
         $display("FAIL b2b_first: got sr %h done %b exp 00 1", sr_out, done); end
      pulse(OP_ASL, 16'h0601);
      wait_end(n);
      vec++; if (n !== 5 + DW) begin miss++;
         $display("FAIL b2b_next_start: got %0d exp %0d", n, 5 + DW); end
      repeat (2) @(negedge clk);
      vec++; if (done_cnt !== 2) begin miss++;
         $display("FAIL b2b_done_cnt: got %0d exp 2", done_cnt); end
      vec++; if (mem[16'h0600] !== 8'h20 || mem[16'h0601] !== 8'h40) begin
         miss++;
         $display("FAIL b2b_mem: got %h %h exp 20 40",
                  mem[16'h0600], mem[16'h0601]); end
      vec++; if (both !== 0) begin miss++;
         $display("FAIL b2b_rd_wr_overlap: got %0d exp 0", both); end
   endtask

   initial begin
      clr();
      test_reset();
      test_asl();
      test_inc_wait();
      test_ops();
      test_illegal();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
